conv_eng: RTL and testbench



---
 rtl/conv_eng.sv | 75 +++++++
 tb/tb_conv_eng.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/conv_eng.sv
// rtl/conv_eng.sv - 20x20 shift register file of 9-bit pixels with a registered 3x3 Gaussian tap
// Rows load from the top and shift down; every row rotates left by one word when columns shift.
module conv_eng (
  input  logic                clk,
  input  logic                reset,
  input  logic [179:0]        data,
  input  logic                rowShift,
  input  logic                colShift,
  output logic [179:0]        res [19:0],
  output logic signed [34:0]  data_o
);

  localparam int SHIFT_RF_2D_ROW = 20;
  localparam int WORD_W          = 9;
  localparam int ROW_W           = SHIFT_RF_2D_ROW * WORD_W;

  logic [ROW_W-1:0]   rf_q [SHIFT_RF_2D_ROW];
  logic [ROW_W-1:0]   rf_d [SHIFT_RF_2D_ROW];
  logic signed [34:0] data_o_q;
  logic signed [34:0] data_o_d;

  function automatic logic signed [34:0] sext(input logic [WORD_W-1:0] w);
    return {{(35-WORD_W){w[WORD_W-1]}}, w};
  endfunction

  always_comb begin
    for (int r = 0; r < SHIFT_RF_2D_ROW; r++) begin
      rf_d[r] = rf_q[r];
    end
    if (rowShift) begin
      rf_d[0] = data;
      for (int r = 1; r < SHIFT_RF_2D_ROW; r++) begin
        rf_d[r] = rf_q[r-1];
      end
    end else if (colShift) begin
      // Word 0 wraps to the top word: a left rotation in word order.
      for (int r = 0; r < SHIFT_RF_2D_ROW; r++) begin
        rf_d[r] = {rf_q[r][WORD_W-1:0], rf_q[r][ROW_W-1:WORD_W]};
      end
    end
  end

  // Kernel weight is 1 << (number of centre coordinates), giving [1 2 1; 2 4 2; 1 2 1].
  always_comb begin
    data_o_d = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        data_o_d = data_o_d + (sext(rf_q[i][WORD_W*j +: WORD_W]) <<< ((i == 1 ? 1 : 0) + (j == 1 ? 1 : 0)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < SHIFT_RF_2D_ROW; r++) begin
        rf_q[r] <= '0;
      end
      data_o_q <= '0;
    end else begin
      for (int r = 0; r < SHIFT_RF_2D_ROW; r++) begin
        rf_q[r] <= rf_d[r];
      end
      data_o_q <= data_o_d;
    end
  end

  always_comb begin
    for (int r = 0; r < SHIFT_RF_2D_ROW; r++) begin
      res[r] = rf_q[r];
    end
  end

  assign data_o = data_o_q;

endmodule

// File: tb/tb_conv_eng.sv
// tb/tb_conv_eng.sv - scoreboard bench for conv_eng
// Word-level reference model; expected kernel results queue at drive time and pop after the edge.
module tb_conv_eng;

  logic               clk = 1'b0;
  logic               reset;
  logic [179:0]       data;
  logic               rowShift;
  logic               colShift;
  logic [179:0]       res [19:0];
  logic signed [34:0] data_o;

  conv_eng dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .rowShift (rowShift),
    .colShift (colShift),
    .res      (res),
    .data_o   (data_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0]         mw [20][20];
  logic signed [34:0] exp_q [$];

  task automatic chk(input string tag, input logic [179:0] got, input logic [179:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int kern();
    int s = 0;
    int k [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += k[i][j] * int'($signed(mw[i][j]));
    return s;
  endfunction

  function automatic logic [179:0] mrow(input int r);
    logic [179:0] v;
    for (int c = 0; c < 20; c++) v[9*c +: 9] = mw[r][c];
    return v;
  endfunction

  function automatic logic [179:0] sx(input logic signed [34:0] v);
    return {{145{v[34]}}, v};
  endfunction

  task automatic check_rows(input string tag);
    for (int r = 0; r < 20; r++) chk($sformatf("%s_row%0d", tag, r), res[r], mrow(r));
  endtask

  task automatic step(input logic rst, input logic rs, input logic cs, input logic [179:0] d);
    logic signed [34:0] e;
    logic [8:0] t;
    @(negedge clk);
    reset = rst; rowShift = rs; colShift = cs; data = d;
    e = rst ? 35'sd0 : 35'(kern());
    exp_q.push_back(e);
    if (rst) begin
      for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) mw[r][c] = '0;
    end else if (rs) begin
      for (int r = 19; r > 0; r--) mw[r] = mw[r-1];
      for (int c = 0; c < 20; c++) mw[0][c] = d[9*c +: 9];
    end else if (cs) begin
      for (int r = 0; r < 20; r++) begin
        t = mw[r][0];
        for (int c = 0; c < 19; c++) mw[r][c] = mw[r][c+1];
        mw[r][19] = t;
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk("sb_empty", 180'd1, 180'd0);
    else chk("data_o", sx(data_o), sx(exp_q.pop_front()));
    check_rows("res");
  endtask

  function automatic logic [179:0] rnd_line();
    logic [179:0] v;
    for (int c = 0; c < 20; c++) v[9*c +: 9] = 9'($urandom);
    return v;
  endfunction

  logic [179:0] la, lb, lc, lramp, l5;

  initial begin
    reset = 1'b0; rowShift = 1'b0; colShift = 1'b0; data = '0;
    la = {20{9'd1}}; lb = {20{9'd2}}; lc = {20{9'd3}}; l5 = {20{9'd5}};
    for (int c = 0; c < 20; c++) lramp[9*c +: 9] = 9'(c);

    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    for (int r = 0; r < 20; r++) chk($sformatf("rst_row%0d", r), res[r], 180'd0);
    chk("rst_data_o", sx(data_o), 180'd0);

    step(0, 1, 0, la);
    step(0, 1, 0, lb);
    step(0, 1, 0, lc);
    chk("load_r0", res[0], lc);
    chk("load_r1", res[1], lb);
    chk("load_r2", res[2], la);
    chk("load_r3", res[3], 180'd0);
    step(0, 0, 0, '0);
    chk("kern_cba", sx(data_o), sx(35'sd32));
    for (int i = 0; i < 17; i++) step(0, 1, 0, rnd_line());
    chk("a_at_r19", res[19], la);
    step(0, 1, 0, rnd_line());
    chk("a_gone", res[19], lb);

    for (int i = 0; i < 3; i++) step(0, 1, 0, la);
    step(0, 0, 0, '0);
    chk("kern_p16", sx(data_o), sx(35'sd16));
    for (int i = 0; i < 3; i++) step(0, 1, 0, {20{9'h1FF}});
    step(0, 0, 0, '0);
    chk("kern_m16", sx(data_o), sx(-35'sd16));

    step(0, 1, 0, lramp);
    step(0, 0, 1, '0);
    chk("rot_w0", 180'(res[0][8:0]), 180'd1);
    chk("rot_w18", 180'(res[0][170:162]), 180'd19);
    chk("rot_w19", 180'(res[0][179:171]), 180'd0);
    for (int i = 0; i < 19; i++) step(0, 0, 1, '0);
    chk("rot_full", res[0], lramp);

    step(0, 1, 1, l5);
    chk("both_r0", res[0], l5);
    chk("both_r1", res[1], lramp);

    for (int i = 0; i < 4; i++) step(0, 1'($urandom), 1'($urandom), rnd_line());
    step(1, 1, 0, rnd_line());
    chk("mid_rst_data_o0", sx(data_o), 180'd0);
    for (int r = 0; r < 20; r++) chk($sformatf("mid_rst_row%0d", r), res[r], 180'd0);
    step(0, 0, 0, '0);
    chk("mid_rst_data_o1", sx(data_o), 180'd0);

    for (int i = 0; i < 60; i++) step(0, 1'($urandom_range(0, 2) == 0), 1'($urandom), rnd_line());
    step(0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
